pipeline_full_subtractor: RTL
=============================

PIPELINE_FULL_SUBTRACTOR -- requirements
Module: pipeline_full_subtractor

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset is synchronous and active-low.
REQ-003 SHALL have port a, input, 4 bits: minuend.
REQ-004 SHALL have port b, input, 4 bits: subtrahend.
REQ-005 SHALL have port bin, input, 1 bit: borrow-in.
REQ-006 SHALL have port in_valid, input, 1 bit: a/b/bin hold a valid operation this cycle.
REQ-007 SHALL have port in_ready, output, 1 bit: block accepts the operation this cycle.
REQ-008 SHALL have port diff, output, 4 bits, registered: result, a - b - bin mod 16.
REQ-009 SHALL have port bout, output, 1 bit, registered: borrow-out; 1 when a < b + bin.
REQ-010 SHALL have port out_valid, output, 1 bit, registered: diff/bout hold a result.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream consumes the result this cycle.

Function
REQ-012 SHALL have 3 register stages:
- S1: captures a, b, bin.
- S2: computes bits [1:0] with a ripple borrow, then registers the partial diff, the mid borrow, and a[3:2]/b[3:2].
- S3: computes bits [3:2] from the mid borrow, then registers diff/bout.
REQ-013 SHALL accept an operation when in_valid and in_ready are both 1 in the same cycle.
REQ-014 SHALL present the result on diff/bout/out_valid exactly 3 cycles after acceptance when out_ready is held at 1.
REQ-015 SHALL sustain one accepted operation per cycle when out_ready is held at 1; no bubbles inserted.
REQ-016 SHALL give each stage k an advance enable en_k = ~valid_k | en_(k+1), with en_4 = out_ready.
REQ-017 SHALL drive in_ready = en_1 combinationally; it is 0 only when all three stages are valid and out_ready is 0.
REQ-018 SHALL hold diff, bout and out_valid stable while out_valid = 1 and out_ready = 0.
REQ-019 SHALL not duplicate, drop or reorder any accepted operation under any out_ready pattern.
REQ-020 SHALL clear a stage valid bit when the stage advances with no valid data from the stage before it.
REQ-021 SHALL load new data into a stage when it advances, and clear the old result from its outputs in the same cycle.
REQ-022 SHALL hold the data registers of any non-advancing stage.
REQ-023 SHALL be exact at the arithmetic boundaries:
- a=0, b=15, bin=1 gives diff=0, bout=1.
- a=15, b=0, bin=0 gives diff=15, bout=0.
REQ-024 SHALL not modify the stage contents for in_valid=1 while in_ready=0; the operation is not accepted.
REQ-025 SHALL treat a, b and bin as don't-care when in_valid=0; they do not affect any output.

Reset
REQ-026 SHALL respond to rst=0 sampled on a clk edge as follows:
- clear all stage valid bits.
- set diff=4'b0000, bout=0, out_valid=0 on that edge.
REQ-027 SHALL clear all S1/S2 data registers to 0 on reset.
REQ-028 SHALL discard all in-flight operations when reset is asserted mid-operation.
REQ-029 SHALL produce no out_valid pulse for discarded operations after rst returns to 1.
REQ-030 SHALL drive in_ready=1 during reset and on the first cycle after reset.
REQ-031 SHALL ignore in_valid while rst=0; no operation is accepted during reset.

Structure
REQ-032 SHALL take the constants from a shared package: WIDTH=4, SLICE=2, STAGES=3.
REQ-033 SHALL place the shared package where a future pipeline_full_adder revision can reuse it.
REQ-034 SHALL implement each 2-bit ripple-borrow slice as one combinational sub-module, full_subtractor_2bit:
- inputs x[1:0], y[1:0], bi.
- outputs d[1:0], bo.
REQ-035 SHALL instantiate full_subtractor_2bit twice, once in S2 and once in S3.
REQ-036 SHALL contain no latches, and no logic clocked on anything other than clk.

Verification
REQ-037 SHALL cover basic latency: out_ready=1; accept a=9, b=4, bin=0 at cycle 0 -> out_valid=1, diff=5, bout=0 at cycle 3.
REQ-038 SHALL cover a negative result: a=4, b=9, bin=0 -> diff=11, bout=1; a=0, b=15, bin=1 -> diff=0, bout=1; a=15, b=15, bin=1 -> diff=15, bout=1.
REQ-039 SHALL cover back-to-back throughput: 16 consecutive operations with a=i, b=15-i, bin=i[0], out_ready=1 -> 16 results on consecutive cycles starting at cycle 3, in order, each equal to the reference model.
REQ-040 SHALL cover backpressure as follows:
- Stimulus: stream 5 operations with in_valid=1, then out_ready=0 for cycles 2-7.
- in_ready goes to 0 once 3 operations are held.
- diff/bout stay stable while stalled.
- All 5 results emerge in order after out_ready returns to 1.
REQ-041 SHALL cover reset mid-flight: accept 2 operations, drive rst=0 for 1 cycle at cycle 1 -> diff=0, bout=0, out_valid=0 after that edge; no out_valid for either operation during the next 5 cycles.
REQ-042 SHALL cover random stress: 10,000 random operations with random in_valid/out_ready -> a scoreboard sees every accepted operation exactly once, in order, with the correct diff/bout.

Source files
------------

// File: rtl/pipeline_full_subtractor_pkg.sv
// Shared constants and types for the 2-bit-sliced pipelined arithmetic blocks.
// Holds nothing subtractor-specific, so a sliced adder can import it unchanged.
package pipeline_full_subtractor_pkg;

  localparam int unsigned WIDTH  = 4;
  localparam int unsigned SLICE  = 2;
  localparam int unsigned STAGES = 3;

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [SLICE-1:0] slice_t;

endpackage

// File: rtl/pipeline_full_subtractor_fs2.sv
// Combinational 2-bit ripple-borrow subtractor slice: d = x - y - bi, bo = borrow out.
module full_subtractor_2bit
  import pipeline_full_subtractor_pkg::*;
(
  input  logic [SLICE-1:0] x,
  input  logic [SLICE-1:0] y,
  input  logic             bi,
  output logic [SLICE-1:0] d,
  output logic             bo
);

  logic [SLICE:0] br;

  // Ripple the borrow from bit 0 upward through the slice.
  always_comb begin
    br    = '0;
    d     = '0;
    br[0] = bi;
    for (int unsigned i = 0; i < SLICE; i++) begin
      d[i]    = x[i] ^ y[i] ^ br[i];
      br[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br[i]);
    end
    bo = br[SLICE];
  end

endmodule

// File: rtl/pipeline_full_subtractor.sv
// Three-stage valid/ready pipelined 4-bit full subtractor.
// S1 captures operands, S2 resolves the low slice, S3 resolves the high slice.
module pipeline_full_subtractor
  import pipeline_full_subtractor_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             out_valid,
  input  logic             out_ready
);

  // Stage 1: raw operands
  logic   s1_v_q,   s1_v_d;
  word_t  s1_a_q,   s1_a_d;
  word_t  s1_b_q,   s1_b_d;
  logic   s1_bin_q, s1_bin_d;
  // Stage 2: low-slice result, mid borrow, high operand bits
  logic   s2_v_q,   s2_v_d;
  slice_t s2_dlo_q, s2_dlo_d;
  logic   s2_bm_q,  s2_bm_d;
  slice_t s2_ahi_q, s2_ahi_d;
  slice_t s2_bhi_q, s2_bhi_d;
  // Stage 3: final result
  logic   s3_v_q,    s3_v_d;
  word_t  s3_diff_q, s3_diff_d;
  logic   s3_bout_q, s3_bout_d;

  logic   en1, en2, en3;
  slice_t lo_d, hi_d;
  logic   lo_bo, hi_bo;

  full_subtractor_2bit u_fs_lo (
    .x  (s1_a_q[SLICE-1:0]),
    .y  (s1_b_q[SLICE-1:0]),
    .bi (s1_bin_q),
    .d  (lo_d),
    .bo (lo_bo)
  );

  full_subtractor_2bit u_fs_hi (
    .x  (s2_ahi_q),
    .y  (s2_bhi_q),
    .bi (s2_bm_q),
    .d  (hi_d),
    .bo (hi_bo)
  );

  // A stage may advance when it is empty or the stage after it advances.
  always_comb begin
    en3 = ~s3_v_q | out_ready;
    en2 = ~s2_v_q | en3;
    en1 = ~s1_v_q | en2;
  end

  // Ready is forced high in reset; the reset branch below still blocks any capture.
  assign in_ready  = en1 | ~rst;
  assign diff      = s3_diff_q;
  assign bout      = s3_bout_q;
  assign out_valid = s3_v_q;

  // Next-state: advancing stages take upstream data (zeroed when invalid), others hold.
  always_comb begin
    s1_v_d    = s1_v_q;
    s1_a_d    = s1_a_q;
    s1_b_d    = s1_b_q;
    s1_bin_d  = s1_bin_q;
    s2_v_d    = s2_v_q;
    s2_dlo_d  = s2_dlo_q;
    s2_bm_d   = s2_bm_q;
    s2_ahi_d  = s2_ahi_q;
    s2_bhi_d  = s2_bhi_q;
    s3_v_d    = s3_v_q;
    s3_diff_d = s3_diff_q;
    s3_bout_d = s3_bout_q;

    if (en1) begin
      s1_v_d   = in_valid;
      s1_a_d   = in_valid ? a   : '0;
      s1_b_d   = in_valid ? b   : '0;
      s1_bin_d = in_valid ? bin : 1'b0;
    end

    if (en2) begin
      s2_v_d   = s1_v_q;
      s2_dlo_d = s1_v_q ? lo_d                  : '0;
      s2_bm_d  = s1_v_q ? lo_bo                 : 1'b0;
      s2_ahi_d = s1_v_q ? s1_a_q[WIDTH-1:SLICE] : '0;
      s2_bhi_d = s1_v_q ? s1_b_q[WIDTH-1:SLICE] : '0;
    end

    if (en3) begin
      s3_v_d    = s2_v_q;
      s3_diff_d = s2_v_q ? {hi_d, s2_dlo_q} : '0;
      s3_bout_d = s2_v_q ? hi_bo            : 1'b0;
    end
  end

  // Pipeline registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_v_q    <= 1'b0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s1_bin_q  <= 1'b0;
      s2_v_q    <= 1'b0;
      s2_dlo_q  <= '0;
      s2_bm_q   <= 1'b0;
      s2_ahi_q  <= '0;
      s2_bhi_q  <= '0;
      s3_v_q    <= 1'b0;
      s3_diff_q <= '0;
      s3_bout_q <= 1'b0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_a_q    <= s1_a_d;
      s1_b_q    <= s1_b_d;
      s1_bin_q  <= s1_bin_d;
      s2_v_q    <= s2_v_d;
      s2_dlo_q  <= s2_dlo_d;
      s2_bm_q   <= s2_bm_d;
      s2_ahi_q  <= s2_ahi_d;
      s2_bhi_q  <= s2_bhi_d;
      s3_v_q    <= s3_v_d;
      s3_diff_q <= s3_diff_d;
      s3_bout_q <= s3_bout_d;
    end
  end

endmodule
